// File: rtl/buck_pwm_generator_if.sv
// Connection between the discharge controllers and the two-phase buck PWM generator.
// The master side issues state and on-time commands; the slave side returns the timebase and gate drives.
interface buck_pwm_generator_if;
   logic [7:0]  current_state;
   logic [15:0] charging_time_0;
   logic [15:0] charging_time_1;
   logic [15:0] timer_buck_4us_0;
   logic [15:0] timer_buck_4us_1;
   logic        cycle_start_0;
   logic        cycle_start_1;
   logic [15:0] on_time_applied_0;
   logic [15:0] on_time_applied_1;
   logic        buck_hs_0;
   logic        buck_ls_0;
   logic        buck_hs_1;
   logic        buck_ls_1;

   modport master (
      output current_state, charging_time_0, charging_time_1,
      input  timer_buck_4us_0, timer_buck_4us_1, cycle_start_0, cycle_start_1,
      input  on_time_applied_0, on_time_applied_1,
      input  buck_hs_0, buck_ls_0, buck_hs_1, buck_ls_1
   );

   modport slave (
      input  current_state, charging_time_0, charging_time_1,
      output timer_buck_4us_0, timer_buck_4us_1, cycle_start_0, cycle_start_1,
      output on_time_applied_0, on_time_applied_1,
      output buck_hs_0, buck_ls_0, buck_hs_1, buck_ls_1
   );
endinterface

// File: rtl/buck_pwm_generator.sv
// Two-phase interleaved buck PWM: free-running 4 us timebase, per-period shadowed on-time
// with clamping, and dead-time separated high-/low-side gates gated by the discharge state.
module buck_pwm_generator #(
   parameter logic [15:0] PERIOD_CYCLES = 16'd400,
   parameter logic [15:0] PHASE_OFFSET  = 16'd200,
   parameter logic [15:0] MAX_ON_TIME   = 16'd360,
   parameter logic [15:0] MIN_ON_TIME   = 16'd8,
   parameter logic [15:0] DEAD_TIME     = 16'd5
) (
   input logic                  clk,
   input logic                  rst_n,
   buck_pwm_generator_if.slave  pwm
);
   localparam logic [7:0]  S_WAIT_BREAKDOWN  = 8'h01;
   localparam logic [7:0]  S_BUCK_INTERLEAVE = 8'h02;
   localparam logic [15:0] LAST_COUNT        = PERIOD_CYCLES - 16'd1;
   localparam logic [15:0] LS_END            = PERIOD_CYCLES - DEAD_TIME;

   typedef enum logic {ST_IDLE, ST_RUN} phase_state_t;

   logic [15:0] cmd          [2];
   logic        active       [2];
   logic [15:0] timer_out    [2];
   logic [15:0] shadow_out   [2];
   logic        cycle_out    [2];
   logic        hs_out       [2];
   logic        ls_out       [2];

   function automatic logic [15:0] clamp_cmd(input logic [15:0] c);
      if (c < MIN_ON_TIME)
         return 16'd0;
      else if (c > MAX_ON_TIME)
         return MAX_ON_TIME;
      else
         return c;
   endfunction

   assign cmd[0]    = pwm.charging_time_0;
   assign cmd[1]    = pwm.charging_time_1;
   // Phase 0 also runs while waiting for breakdown; phase 1 only in full interleave.
   assign active[0] = (pwm.current_state == S_BUCK_INTERLEAVE) ||
                      (pwm.current_state == S_WAIT_BREAKDOWN);
   assign active[1] = (pwm.current_state == S_BUCK_INTERLEAVE);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_phase
         localparam logic [15:0] TIMER_INIT = (gi == 0) ? 16'd0 : PHASE_OFFSET;

         phase_state_t state_reg;
         logic [15:0]  timer_reg;
         logic [15:0]  timer_next;
         logic [15:0]  shadow_reg;
         logic         cycle_start_reg;
         logic         hs_reg;
         logic         ls_reg;
         logic         at_end;
         logic         hs_next;
         logic         ls_next;

         always_comb begin
            at_end     = (timer_reg == LAST_COUNT);
            timer_next = at_end ? 16'd0 : timer_reg + 16'd1;
            hs_next    = (shadow_reg != 16'd0) && (timer_reg < shadow_reg);
            ls_next    = (shadow_reg != 16'd0) &&
                         (timer_reg >= shadow_reg + DEAD_TIME) &&
                         (timer_reg < LS_END);
         end

         // Entry into RUN only at the period boundary keeps the first pulse whole;
         // exit is immediate and drops both gates together, so no dead time is needed.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_reg       <= ST_IDLE;
               timer_reg       <= TIMER_INIT;
               shadow_reg      <= 16'd0;
               cycle_start_reg <= 1'b0;
               hs_reg          <= 1'b0;
               ls_reg          <= 1'b0;
            end else begin
               timer_reg       <= timer_next;
               cycle_start_reg <= (timer_next == LAST_COUNT);
               if (at_end)
                  shadow_reg <= clamp_cmd(cmd[gi]);
               case (state_reg)
                  ST_IDLE: begin
                     hs_reg <= 1'b0;
                     ls_reg <= 1'b0;
                     if (at_end && active[gi])
                        state_reg <= ST_RUN;
                  end
                  ST_RUN: begin
                     if (!active[gi]) begin
                        state_reg <= ST_IDLE;
                        hs_reg    <= 1'b0;
                        ls_reg    <= 1'b0;
                     end else begin
                        hs_reg <= hs_next;
                        ls_reg <= ls_next;
                     end
                  end
                  default: begin
                     state_reg <= ST_IDLE;
                     hs_reg    <= 1'b0;
                     ls_reg    <= 1'b0;
                  end
               endcase
            end
         end

         assign timer_out[gi]  = timer_reg;
         assign shadow_out[gi] = shadow_reg;
         assign cycle_out[gi]  = cycle_start_reg;
         assign hs_out[gi]     = hs_reg;
         assign ls_out[gi]     = ls_reg;
      end
   endgenerate

   assign pwm.timer_buck_4us_0  = timer_out[0];
   assign pwm.timer_buck_4us_1  = timer_out[1];
   assign pwm.cycle_start_0     = cycle_out[0];
   assign pwm.cycle_start_1     = cycle_out[1];
   assign pwm.on_time_applied_0 = shadow_out[0];
   assign pwm.on_time_applied_1 = shadow_out[1];
   assign pwm.buck_hs_0         = hs_out[0];
   assign pwm.buck_ls_0         = ls_out[0];
   assign pwm.buck_hs_1         = hs_out[1];
   assign pwm.buck_ls_1         = ls_out[1];
endmodule

// File: tb/tb_buck_pwm_generator.sv
// Directed bench for buck_pwm_generator: timebase, shadowed clamping, gate shapes,
// state gating and asynchronous reset, with expected values worked out by hand.
module tb_buck_pwm_generator;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   pos = 0;

   int   p_hs0, p_ls0, p_hs1, p_ls1, p_shape, p_ovl, p_tmr, p_cs0_k, p_cs1_k, p_cs_n, p_app0;
   int   cnt;

   buck_pwm_generator_if pwm ();

   buck_pwm_generator dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pwm   (pwm)
   );

   always #5 clk = ~clk;

   // pos mirrors the expected value of timer_buck_4us_0 at each falling edge.
   task automatic tick();
      @(negedge clk);
      pos = (pos + 1) % 400;
   endtask

   task automatic wait_to(input int p);
      for (int i = 0; i < 400 && pos != p; i++) tick();
   endtask

   // Samples one full period (timer_0 = 0..399), starting from pos == 399.
   task automatic run_period(input int exp_t, input int chg_k, input logic [15:0] chg_ct);
      logic exp_hs, exp_ls;
      wait_to(399);
      p_hs0 = 0; p_ls0 = 0; p_hs1 = 0; p_ls1 = 0; p_shape = 0; p_ovl = 0; p_tmr = 0;
      p_cs0_k = -1; p_cs1_k = -1; p_cs_n = 0; p_app0 = -1;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (k == 0) p_app0 = int'(pwm.on_time_applied_0);
         exp_hs = (exp_t != 0) && (k >= 1) && (k <= exp_t);
         exp_ls = (exp_t != 0) && (k >= exp_t + 6) && (k <= 395);
         if (pwm.buck_hs_0 !== exp_hs || pwm.buck_ls_0 !== exp_ls) p_shape++;
         if (pwm.buck_hs_0 === 1'b1) p_hs0++;
         if (pwm.buck_ls_0 === 1'b1) p_ls0++;
         if (pwm.buck_hs_1 === 1'b1) p_hs1++;
         if (pwm.buck_ls_1 === 1'b1) p_ls1++;
         if ((pwm.buck_hs_0 && pwm.buck_ls_0) || (pwm.buck_hs_1 && pwm.buck_ls_1)) p_ovl++;
         if (pwm.timer_buck_4us_0 !== 16'(k) || pwm.timer_buck_4us_1 !== 16'((k + 200) % 400)) p_tmr++;
         if (pwm.cycle_start_0 === 1'b1) begin p_cs_n++; p_cs0_k = k; end
         if (pwm.cycle_start_1 === 1'b1) begin p_cs_n++; p_cs1_k = k; end
         if (k == chg_k) pwm.charging_time_0 = chg_ct;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pwm.current_state   = 8'h02;
      pwm.charging_time_0 = 16'd120;
      pwm.charging_time_1 = 16'd120;
      repeat (3) @(negedge clk);
      checks++; if (pwm.timer_buck_4us_0 !== 16'd0) begin errors++; $display("FAIL rst_timer0: got %0d expected 0", pwm.timer_buck_4us_0); end
      checks++; if (pwm.timer_buck_4us_1 !== 16'd200) begin errors++; $display("FAIL rst_timer1: got %0d expected 200", pwm.timer_buck_4us_1); end
      checks++; if ({pwm.buck_hs_0, pwm.buck_ls_0, pwm.buck_hs_1, pwm.buck_ls_1} !== 4'b0) begin errors++; $display("FAIL rst_gates: got %b expected 0000", {pwm.buck_hs_0, pwm.buck_ls_0, pwm.buck_hs_1, pwm.buck_ls_1}); end
      checks++; if ({pwm.cycle_start_0, pwm.cycle_start_1} !== 2'b0) begin errors++; $display("FAIL rst_cycle_start: got %b expected 00", {pwm.cycle_start_0, pwm.cycle_start_1}); end
      checks++; if (pwm.on_time_applied_0 !== 16'd0 || pwm.on_time_applied_1 !== 16'd0) begin errors++; $display("FAIL rst_applied: got %0d/%0d expected 0/0", pwm.on_time_applied_0, pwm.on_time_applied_1); end
      rst_n = 1'b1;
      pos = 0;
      tick();
      checks++; if (pwm.timer_buck_4us_0 !== 16'd1 || pwm.timer_buck_4us_1 !== 16'd201) begin errors++; $display("FAIL first_count: got %0d/%0d expected 1/201", pwm.timer_buck_4us_0, pwm.timer_buck_4us_1); end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_nominal();
      wait_to(399);
      checks++; if (pwm.cycle_start_0 !== 1'b1) begin errors++; $display("FAIL first_cycle_start0: got %b expected 1", pwm.cycle_start_0); end
      checks++; if (pwm.buck_hs_0 !== 1'b0) begin errors++; $display("FAIL hs0_before_wrap: got %b expected 0", pwm.buck_hs_0); end
      run_period(120, -1, 16'd0);
      checks++; if (p_app0 !== 120) begin errors++; $display("FAIL nom_applied0: got %0d expected 120", p_app0); end
      checks++; if (p_hs0 !== 120) begin errors++; $display("FAIL nom_hs0_width: got %0d expected 120", p_hs0); end
      checks++; if (p_ls0 !== 270) begin errors++; $display("FAIL nom_ls0_width: got %0d expected 270", p_ls0); end
      checks++; if (p_shape !== 0) begin errors++; $display("FAIL nom_dead_time_shape: got %0d bad samples expected 0", p_shape); end
      checks++; if (p_ovl !== 0) begin errors++; $display("FAIL nom_overlap: got %0d expected 0", p_ovl); end
      checks++; if (p_hs1 !== 120 || p_ls1 !== 270) begin errors++; $display("FAIL nom_phase1: got hs %0d ls %0d expected 120/270", p_hs1, p_ls1); end
      checks++; if (p_tmr !== 0) begin errors++; $display("FAIL nom_timers: got %0d bad samples expected 0", p_tmr); end
      checks++; if (p_cs0_k !== 399 || p_cs1_k !== 199 || p_cs_n !== 2) begin errors++; $display("FAIL nom_cycle_start: got k0 %0d k1 %0d n %0d expected 399/199/2", p_cs0_k, p_cs1_k, p_cs_n); end
      $display("test_nominal done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_clamp();
      pwm.charging_time_0 = 16'd500;
      run_period(360, -1, 16'd0);
      checks++; if (p_app0 !== 360) begin errors++; $display("FAIL max_applied0: got %0d expected 360", p_app0); end
      checks++; if (p_hs0 !== 360 || p_ls0 !== 30) begin errors++; $display("FAIL max_widths: got hs %0d ls %0d expected 360/30", p_hs0, p_ls0); end
      checks++; if (p_shape !== 0 || p_ovl !== 0) begin errors++; $display("FAIL max_shape: got %0d bad, %0d overlap expected 0/0", p_shape, p_ovl); end
      pwm.charging_time_0 = 16'd5;
      run_period(0, -1, 16'd0);
      checks++; if (p_app0 !== 0) begin errors++; $display("FAIL min_applied0: got %0d expected 0", p_app0); end
      checks++; if (p_hs0 !== 0 || p_ls0 !== 0) begin errors++; $display("FAIL min_gates_off: got hs %0d ls %0d expected 0/0", p_hs0, p_ls0); end
      pwm.charging_time_0 = 16'd8;
      run_period(8, -1, 16'd0);
      checks++; if (p_app0 !== 8) begin errors++; $display("FAIL min_edge_applied0: got %0d expected 8", p_app0); end
      checks++; if (p_hs0 !== 8 || p_shape !== 0) begin errors++; $display("FAIL min_edge_shape: got hs %0d bad %0d expected 8/0", p_hs0, p_shape); end
      $display("test_clamp done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_mid_period_change();
      pwm.charging_time_0 = 16'd120;
      run_period(120, 50, 16'd200);
      checks++; if (p_hs0 !== 120 || p_shape !== 0) begin errors++; $display("FAIL mid_keep_old: got hs %0d bad %0d expected 120/0", p_hs0, p_shape); end
      run_period(200, -1, 16'd0);
      checks++; if (p_app0 !== 200) begin errors++; $display("FAIL mid_next_applied: got %0d expected 200", p_app0); end
      checks++; if (p_hs0 !== 200 || p_ls0 !== 190 || p_shape !== 0) begin errors++; $display("FAIL mid_next_widths: got hs %0d ls %0d bad %0d expected 200/190/0", p_hs0, p_ls0, p_shape); end
      $display("test_mid_period_change done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_state_drop();
      pwm.charging_time_0 = 16'd120;
      wait_to(60);
      checks++; if (pwm.buck_hs_0 !== 1'b1 || pwm.buck_ls_1 !== 1'b1) begin errors++; $display("FAIL drop_before: got hs0 %b ls1 %b expected 1/1", pwm.buck_hs_0, pwm.buck_ls_1); end
      pwm.current_state = 8'h80;
      tick();
      checks++; if ({pwm.buck_hs_0, pwm.buck_ls_0, pwm.buck_hs_1, pwm.buck_ls_1} !== 4'b0) begin errors++; $display("FAIL drop_truncate: got %b expected 0000", {pwm.buck_hs_0, pwm.buck_ls_0, pwm.buck_hs_1, pwm.buck_ls_1}); end
      cnt = 0;
      for (int i = 0; i < 400 && pos != 399; i++) begin
         if (pos == 100) pwm.current_state = 8'h02;
         tick();
         if (pwm.buck_hs_0 === 1'b1 || pwm.buck_ls_0 === 1'b1) cnt++;
      end
      checks++; if (cnt !== 0) begin errors++; $display("FAIL drop_no_mid_reentry: got %0d gate-high samples expected 0", cnt); end
      run_period(120, -1, 16'd0);
      checks++; if (p_hs0 !== 120 || p_shape !== 0) begin errors++; $display("FAIL drop_resume: got hs %0d bad %0d expected 120/0", p_hs0, p_shape); end
      checks++; if (p_hs1 !== 120) begin errors++; $display("FAIL drop_resume_phase1: got hs1 %0d expected 120", p_hs1); end
      $display("test_state_drop done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_wait_breakdown();
      wait_to(399);
      pwm.current_state = 8'h01;
      run_period(120, -1, 16'd0);
      checks++; if (p_hs0 !== 120 || p_shape !== 0) begin errors++; $display("FAIL wb_phase0: got hs %0d bad %0d expected 120/0", p_hs0, p_shape); end
      checks++; if (p_hs1 !== 0 || p_ls1 !== 0) begin errors++; $display("FAIL wb_phase1_off: got hs %0d ls %0d expected 0/0", p_hs1, p_ls1); end
      checks++; if (p_cs0_k !== 399 || p_cs1_k !== 199 || p_cs_n !== 2) begin errors++; $display("FAIL wb_cycle_start: got k0 %0d k1 %0d n %0d expected 399/199/2", p_cs0_k, p_cs1_k, p_cs_n); end
      $display("test_wait_breakdown done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_async_reset();
      pwm.current_state = 8'h02;
      wait_to(30);
      checks++; if (pwm.buck_hs_0 !== 1'b1) begin errors++; $display("FAIL ares_before: got hs0 %b expected 1", pwm.buck_hs_0); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({pwm.buck_hs_0, pwm.buck_ls_0, pwm.buck_hs_1, pwm.buck_ls_1} !== 4'b0) begin errors++; $display("FAIL ares_gates: got %b expected 0000", {pwm.buck_hs_0, pwm.buck_ls_0, pwm.buck_hs_1, pwm.buck_ls_1}); end
      checks++; if (pwm.timer_buck_4us_0 !== 16'd0 || pwm.timer_buck_4us_1 !== 16'd200) begin errors++; $display("FAIL ares_timers: got %0d/%0d expected 0/200", pwm.timer_buck_4us_0, pwm.timer_buck_4us_1); end
      checks++; if (pwm.on_time_applied_0 !== 16'd0 || pwm.on_time_applied_1 !== 16'd0) begin errors++; $display("FAIL ares_applied: got %0d/%0d expected 0/0", pwm.on_time_applied_0, pwm.on_time_applied_1); end
      @(negedge clk);
      rst_n = 1'b1;
      $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_clamp();
      test_mid_period_change();
      test_state_drop();
      test_wait_breakdown();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/buck_pwm_generator.md
Name: buck_pwm_generator

Overview:
- Two-phase interleaved buck PWM generator that consumes the per-phase inductor charging-time commands produced by the discharge controllers (open-loop or closed-loop).
- Owns the 4 us switching timebase: it generates timer_buck_4us_0/1, which the controllers count against.
- Latches charging-time commands once per period (shadowed), clamps them, and drives high-side/low-side gates with dead time.
- Gates are driven only in discharge states that allow buck operation.

Parameters:
- PERIOD_CYCLES, 16'd400, switching period in clk cycles (4 us at 100 MHz); timers count 0..PERIOD_CYCLES-1
- PHASE_OFFSET, 16'd200, phase-1 timer offset relative to phase 0 (180 deg)
- MAX_ON_TIME, 16'd360, upper clamp on applied on-time
- MIN_ON_TIME, 16'd8, commands below this (and nonzero) are dropped to 0
- DEAD_TIME, 16'd5, cycles with both gates low around every transition

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- current_state  in  8  discharge FSM state (one-hot codes plus 8'h00)
- charging_time_0  in  16  phase-0 on-time command in clk cycles
- charging_time_1  in  16  phase-1 on-time command in clk cycles
- timer_buck_4us_0  out  16  phase-0 period timer
- timer_buck_4us_1  out  16  phase-1 period timer
- cycle_start_0  out  1  one-cycle pulse when timer_buck_4us_0 == PERIOD_CYCLES-1
- cycle_start_1  out  1  same for phase 1
- on_time_applied_0  out  16  shadow on-time in use for phase 0
- on_time_applied_1  out  16  shadow on-time in use for phase 1
- buck_hs_0, buck_ls_0  out  1 each  phase-0 high-/low-side gate, active high
- buck_hs_1, buck_ls_1  out  1 each  phase-1 high-/low-side gate, active high

Behaviour:
- Reset (async):
  - timer_0 = 0, timer_1 = PHASE_OFFSET.
  - All gates, cycle_start_n and on_time_applied_n = 0.
  - Both phase FSMs in IDLE.
- Timers:
  - Free-run in every state: increment by 1 each clk; wrap to 0 after PERIOD_CYCLES-1.
  - Never reset by current_state.
  - Phase 1 stays exactly PHASE_OFFSET ahead modulo PERIOD_CYCLES.
- cycle_start_n: registered; high during the cycle in which timer_n == PERIOD_CYCLES-1.
- Shadow latch, evaluated when timer_n == PERIOD_CYCLES-1. Value takes effect from the cycle where timer_n == 0:
  - cmd == 0 or cmd < MIN_ON_TIME -> 0
  - cmd > MAX_ON_TIME -> MAX_ON_TIME
  - otherwise cmd
- Command changes mid-period have no effect until the next boundary.
- Active states:
  - Phase 0: S_BUCK_INTERLEAVE (8'h02) or S_WAIT_BREAKDOWN (8'h01).
  - Phase 1: S_BUCK_INTERLEAVE only.
  - Every other code, including 8'h00, 8'h04 and 8'h80, is inactive.
- Phase FSM (independent per phase):
  - IDLE -> RUN: only at the boundary (timer_n == PERIOD_CYCLES-1) with current_state active. Never enters mid-period.
  - RUN -> IDLE: in the cycle current_state is sampled inactive. Gates go low on the next clk edge, truncating any pulse. No dead-time wait is needed since both gates go low.
  - In IDLE: both gates 0; the shadow still updates.
- Gate equations in RUN, with t = timer_n and T = on_time_applied_n. Registered, so each gate appears one clk after the timer value it is decoded from:
  - hs = (T != 0) && (t < T)
  - ls = (T != 0) && (t >= T + DEAD_TIME) && (t < PERIOD_CYCLES - DEAD_TIME)
  - Result for T = 120: hs high 120 cycles, ls high 270 cycles per period, 5 low cycles before and after ls.
- T == 0: both gates low for the whole period, with no synchronous-rectifier conduction.
- Invariant: hs_n && ls_n is never 1 in any cycle. This is a must-hold property for verification.
- MAX_ON_TIME <= PERIOD_CYCLES - 2*DEAD_TIME is a required parameter constraint. With MAX_ON_TIME = 360, ls still gets 30 cycles.
- Arithmetic: all compares are 16-bit unsigned; T + DEAD_TIME cannot overflow given the clamp.

Test Plan:
- Reset release, current_state = 8'h02, charging_time_0 = 120 -> timer_1 starts at 200. First hs_0 pulse follows the first wrap of timer_0 and is 120 cycles wide; ls_0 is 270 cycles wide; a 5-cycle gap on each side of ls_0; hs_0 & ls_0 never both high.
- charging_time_0 = 500 -> on_time_applied_0 = 360, hs_0 = 360 cycles. charging_time_0 = 5 -> applied 0, both phase-0 gates low all period.
- charging_time_0 changes 120 -> 200 when timer_0 = 50 -> current period keeps 120-cycle hs_0; next period gives 200.
- State 8'h02 -> 8'h80 while hs_0 is high at timer_0 = 60 -> hs_0/hs_1 low on the next edge. Returning to 8'h02 mid-period gives no pulse until after the next wrap.
- current_state = 8'h01 -> phase 0 switches, phase 1 stays off; cycle_start_0/1 still pulse every 400 cycles, 200 cycles apart.
- Assert rst_n low mid-pulse -> all gates drop immediately (asynchronously), timers return to 0/200, on_time_applied = 0.
